// File: rtl/uart_rx_ram_loader.sv
// 8N1 UART receiver feeding a RAM loader: byte pairs are packed high-byte-first
// into 16-bit words and written to consecutive addresses starting at 0.
module uart_rx_ram_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 6,
  parameter int NUM_WORDS    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  input  logic              load_start,
  output logic              write_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic [15:0]       data_to_ram,
  output logic              load_busy,
  output logic              load_done,
  output logic              frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_IDLE, LD_ARMED, LD_DONE} ld_state_t;

  logic             rx_sync_p0, rx_sync_p1;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             err_wait;
  logic             byte_vld_p0;
  logic             frame_err_p0;

  ld_state_t        ld_state;
  logic             phase_high;
  logic [7:0]       held_byte;

  // Stage p0/p1: two-flop synchronizer; idles high so reset cannot fake a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  // Receiver: byte_vld_p0 / frame_err_p0 are single-cycle results of the stop-bit sample
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      err_wait     <= 1'b0;
      byte_vld_p0  <= 1'b0;
      frame_err_p0 <= 1'b0;
    end else begin
      byte_vld_p0  <= 1'b0;
      frame_err_p0 <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (err_wait) begin
            if (rx_sync_p1) err_wait <= 1'b0;
          end else if (!rx_sync_p1) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_sync_p1, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync_p1) begin
              byte_vld_p0 <= 1'b1;
            end else begin
              frame_err_p0 <= 1'b1;
              err_wait     <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader: address advances on the edge that ends the write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state            <= LD_IDLE;
      phase_high          <= 1'b1;
      write_enable_to_ram <= 1'b0;
      address_to_ram      <= '0;
      data_to_ram         <= '0;
      load_busy           <= 1'b0;
      load_done           <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      write_enable_to_ram <= 1'b0;
      if (frame_err_p0) frame_error <= 1'b1;
      case (ld_state)
        LD_IDLE, LD_DONE: begin
          if (load_start) begin
            ld_state       <= LD_ARMED;
            address_to_ram <= '0;
            load_done      <= 1'b0;
            load_busy      <= 1'b1;
            frame_error    <= 1'b0;
            phase_high     <= 1'b1;
          end
        end
        LD_ARMED: begin
          if (write_enable_to_ram) begin
            if (address_to_ram == LAST_ADDR) begin
              ld_state  <= LD_DONE;
              load_busy <= 1'b0;
              load_done <= 1'b1;
            end else begin
              address_to_ram <= address_to_ram + 1'b1;
            end
          end
          if (frame_err_p0) begin
            phase_high <= 1'b1;
          end else if (byte_vld_p0) begin
            if (phase_high) begin
              held_byte  <= shift_reg;
              phase_high <= 1'b0;
            end else begin
              data_to_ram         <= {held_byte, shift_reg};
              write_enable_to_ram <= 1'b1;
              phase_high          <= 1'b1;
            end
          end
        end
        default: ld_state <= LD_IDLE;
      endcase
    end
  end

endmodule
